t07_ext_mem_interface: RTL
==========================

T07_EXT_MEM_INTERFACE -- requirements
Module: t07_ext_mem_interface

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: the number of BUSY cycles without bus_ack before the transaction is aborted (effective only with T07_MEMIF_TIMEOUT_EN).
REQ-002 clk  in  1  sole clock; all flops update on its rising edge.
REQ-003 rst  in  1  reset, synchronous and active-high.
REQ-004 rwi  in  2  CPU-side request: 00 idle, 01 write, 10 read, 11 reserved (treated as idle).
REQ-005 addr_in  in  32  CPU-side byte address.
REQ-006 wdata_in  in  32  CPU-side store data.
REQ-007 sel_in  in  4  CPU-side byte-lane enables.
REQ-008 busy  out  1  registered; high while a bus transaction is outstanding.
REQ-009 rdata_out  out  32  registered read data, held until the next completed read.
REQ-010 err_out  out  1  one-cycle pulse when a transaction aborts on timeout.
REQ-011 bus_cyc, bus_stb, bus_we  out  1 each  Wishbone-style cycle, strobe and write-enable.
REQ-012 bus_adr, bus_dat_o  out  32 each; bus_sel  out  4: registered copies of the accepted request.
REQ-013 bus_ack  in  1; bus_dat_i  in  32: slave acknowledge and read data.

Function
REQ-014 The FSM shall have three states: IDLE, BUSY and DONE, encoded per the shared package.
REQ-015 In IDLE with rwi = 01 or 10 at edge k, the block shall latch addr_in, wdata_in and sel_in, and set bus_we = (rwi == 01).
REQ-016 On that same accept at edge k, the FSM shall enter BUSY with bus_cyc = bus_stb = busy = 1 from cycle k+1.
REQ-017 In IDLE with rwi = 00 or 11, the FSM shall remain in IDLE and no bus signal shall assert.
REQ-018 In BUSY, the latched bus_adr, bus_dat_o, bus_sel and bus_we shall not change, regardless of CPU-side input changes.
REQ-019 In BUSY with bus_ack = 1 at edge m, the block shall capture bus_dat_i into rdata_out (reads only; writes leave rdata_out unchanged).
REQ-020 On that same ack at edge m, the block shall deassert bus_cyc, bus_stb and busy from cycle m+1 and enter DONE.
REQ-021 DONE shall last exactly one cycle with busy = 0, then return to IDLE; requests present during DONE shall be ignored.
REQ-022 Busy-high duration shall equal the number of ack-wait cycles plus one (minimum 1 cycle, when ack arrives in the first BUSY cycle), so that the CPU can detect the falling edge.
REQ-023 bus_ack in IDLE or DONE shall be ignored.
REQ-024 bus_dat_o and bus_sel shall be driven to 0 outside BUSY.
REQ-025 bus_adr shall hold its last value outside BUSY.

Reset
REQ-026 When rst = 1 at an edge, state shall become IDLE and busy, bus_cyc, bus_stb, bus_we, bus_adr, bus_dat_o, bus_sel, rdata_out and err_out shall all become 0 from the next cycle.
REQ-027 A reset asserted mid-BUSY shall abandon the transaction without an err_out pulse.
REQ-028 After reset, a bus_ack arriving late from the abandoned transaction shall have no effect.

Configuration
REQ-029 With T07_MEMIF_TIMEOUT_EN defined, a counter shall clear on entry to BUSY and increment every BUSY cycle without bus_ack.
REQ-030 With T07_MEMIF_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYCLES the FSM shall enter DONE as on an ack.
REQ-031 On a timeout with T07_MEMIF_TIMEOUT_EN defined, rdata_out shall be left unchanged and err_out shall pulse high for the DONE cycle.
REQ-032 On a timeout, an ack coinciding with the terminal count shall take priority: the transaction completes normally with no error.
REQ-033 Without T07_MEMIF_TIMEOUT_EN, BUSY shall wait indefinitely for bus_ack, err_out shall be tied to 0, and no counter logic shall be compiled.

Structure
REQ-034 Shared package t07_memif_pkg shall hold the typedef memif_state_t and the rwi constants RWI_IDLE = 2'b00, RWI_WRITE = 2'b01, RWI_READ = 2'b10.
REQ-035 Shared package t07_memif_pkg shall also hold the default value of TIMEOUT_CYCLES.
REQ-036 The timeout counter shall be the single sub-module t07_memif_timeout (inputs: clear, enable; output: expired), instantiated only under T07_MEMIF_TIMEOUT_EN.

Verification
REQ-037 Read: rwi = 10, addr_in = 0x0000_1004, ack two cycles after bus_stb with bus_dat_i = 0xCAFE_F00D -> bus_adr = 0x1004, busy high 3 cycles, then rdata_out = 0xCAFE_F00D and 1 DONE cycle.
REQ-038 Write: rwi = 01, wdata_in = 0x1234_5678, sel_in = 0xF, immediate ack -> bus_we = 1, bus_dat_o = 0x1234_5678, busy high 1 cycle, rdata_out unchanged.
REQ-039 Input change: alter addr_in and wdata_in while BUSY -> bus_adr and bus_dat_o stay at the latched values.
REQ-040 Timeout with TIMEOUT_CYCLES = 8, macro defined, no ack -> busy drops after 8 cycles, err_out is a 1-cycle pulse, rdata_out unchanged; with ack on cycle 8 -> no error.
REQ-041 Reset mid-BUSY, then ack -> all outputs 0 one cycle after rst, the ack is ignored and the next request works normally.
REQ-042 Back-to-back: rwi held at 10 -> transactions are separated by exactly one DONE cycle and an IDLE accept; rwi = 11 never starts a transaction.

Source files
------------

// File: rtl/t07_ext_mem_interface_pkg.sv
// Shared types and constants for the CPU-to-Wishbone memory bridge.
// Holds the FSM encoding, CPU request codes and the default watchdog length.
package t07_memif_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10
   } memif_state_t;

   localparam logic [1:0] RWI_IDLE  = 2'b00;
   localparam logic [1:0] RWI_WRITE = 2'b01;
   localparam logic [1:0] RWI_READ  = 2'b10;

   localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/t07_ext_mem_interface_if.sv
// Wishbone-style single-master bus between the bridge and the external memory slave.
// The bridge drives the request side, the slave returns ack and read data.
interface t07_ext_mem_interface_if;

   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [31:0] dat_o;
   logic [3:0]  sel;
   logic        ack;
   logic [31:0] dat_i;

   modport master (
      output cyc, stb, we, adr, dat_o, sel,
      input  ack, dat_i
   );

   modport slave (
      input  cyc, stb, we, adr, dat_o, sel,
      output ack, dat_i
   );

endinterface

// File: rtl/t07_ext_mem_interface_timeout.sv
// Watchdog for the BUSY state: expired is high in the BUSY cycle that would complete
// TIMEOUT_CYCLES consecutive cycles without bus_ack.
module t07_memif_timeout
   import t07_memif_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

   // count holds the number of already-finished ack-less cycles, so the current
   // cycle is the one that brings the total to TIMEOUT_CYCLES.
   logic [CW-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 1'b1;
      end
   end

   assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/t07_ext_mem_interface.sv
// CPU-to-Wishbone bridge: request accepted in IDLE, bus/busy registered next cycle, one DONE cycle after ack.
// Define T07_MEMIF_TIMEOUT_EN to abort ack-less transactions after TIMEOUT_CYCLES with an err_out pulse.
module t07_ext_mem_interface
   import t07_memif_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [1:0]              rwi,
   input  logic [31:0]             addr_in,
   input  logic [31:0]             wdata_in,
   input  logic [3:0]              sel_in,
   output logic                    busy,
   output logic [31:0]             rdata_out,
   output logic                    err_out,
   t07_ext_mem_interface_if.master bus
);

   memif_state_t state;
   logic         req_vld;
   logic         finish;

   always_comb begin
      req_vld = 1'b0;
      case (rwi)
         RWI_WRITE, RWI_READ: req_vld = 1'b1;
         RWI_IDLE:            req_vld = 1'b0;
         default:             req_vld = 1'b0;
      endcase
   end

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef T07_MEMIF_TIMEOUT_EN
   logic expired;

   t07_memif_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (state == ST_IDLE && req_vld),
      .enable  (state == ST_BUSY && !bus.ack),
      .expired (expired)
   );

   assign finish = bus.ack | expired;
`else
   assign finish  = bus.ack;
   assign err_out = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         busy      <= 1'b0;
         rdata_out <= '0;
         bus.cyc   <= 1'b0;
         bus.stb   <= 1'b0;
         bus.we    <= 1'b0;
         bus.adr   <= '0;
         bus.dat_o <= '0;
         bus.sel   <= '0;
`ifdef T07_MEMIF_TIMEOUT_EN
         err_out   <= 1'b0;
`endif
      end else begin
`ifdef T07_MEMIF_TIMEOUT_EN
         err_out <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (req_vld) begin
                  state     <= ST_BUSY;
                  busy      <= 1'b1;
                  bus.cyc   <= 1'b1;
                  bus.stb   <= 1'b1;
                  bus.we    <= (rwi == RWI_WRITE);
                  bus.adr   <= addr_in;
                  bus.dat_o <= wdata_in;
                  bus.sel   <= sel_in;
               end
            end
            ST_BUSY: begin
               if (finish) begin
                  state     <= ST_DONE;
                  busy      <= 1'b0;
                  bus.cyc   <= 1'b0;
                  bus.stb   <= 1'b0;
                  bus.we    <= 1'b0;
                  bus.dat_o <= '0;
                  bus.sel   <= '0;
                  // An ack on the terminal count wins over the watchdog.
                  if (bus.ack && !bus.we) begin
                     rdata_out <= bus.dat_i;
                  end
`ifdef T07_MEMIF_TIMEOUT_EN
                  err_out <= ~bus.ack;
`endif
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
